// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared widths, FSM encoding and timing defaults for the AES-128 decrypt path
package aes_pkg;
  localparam int BLOCK_W     = 128;
  localparam int WORD_W      = 32;
  localparam int BEATS       = 4;
  localparam int LATENCY_DEF = 41;
  localparam int KEY_LAT_DEF = 10;

  typedef enum logic [1:0] {
    NO_KEY = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_t;
endpackage

// File: rtl/valid_delay_line.sv
// rtl/valid_delay_line.sv - DEPTH-stage 1-bit shift register tracking blocks through the core
module valid_delay_line #(
  parameter int DEPTH = 41
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);
  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr <= '0;
    end else begin
      sr <= {sr[DEPTH-2:0], din};
    end
  end

  assign dout = sr[DEPTH-1];
endmodule

// File: rtl/inv_cipher_loader.sv
// rtl/inv_cipher_loader.sv - word-to-block feeder for the pipelined AES-128 decryption core
module inv_cipher_loader
  import aes_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEF,
  parameter int KEY_LAT = KEY_LAT_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_is_key,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [BLOCK_W-1:0] key,
  output logic [BLOCK_W-1:0] ciphertext,
  output logic               pt_valid,
  output logic               busy,
  output logic               key_ok
);
  localparam int IW = $clog2(LATENCY + 1);
  localparam int SW = $clog2(KEY_LAT + 1);
  localparam int SH = BLOCK_W - WORD_W;
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  state_t          state;
  logic [1:0]      kcnt, dcnt;
  logic [SH-1:0]   kshadow, dshadow;
  logic [SW-1:0]   settle_cnt;
  logic [IW-1:0]   inflight, inflight_next;
  logic            key_pending;
  logic            key_fire, data_fire, issue, dl_out;

  // A stalled key blocks new blocks from starting so the pipeline can drain.
  always_comb begin
    in_ready = 1'b0;
    unique case (state)
      NO_KEY: in_ready = in_is_key;
      SETTLE: in_ready = 1'b0;
      RUN: begin
        if (in_is_key)
          in_ready = (dcnt == 2'd0) && (inflight == '0);
        else
          in_ready = (kcnt == 2'd0) &&
                     !(key_pending && (dcnt == 2'd0) && (inflight != '0));
      end
      default: in_ready = 1'b0;
    endcase
  end

  assign key_fire  = in_valid & in_ready & in_is_key;
  assign data_fire = in_valid & in_ready & ~in_is_key;
  assign issue     = data_fire && (dcnt == LAST_BEAT);

  always_comb begin
    inflight_next = inflight;
    if (issue && !pt_valid)
      inflight_next = inflight + IW'(1);
    else if (!issue && pt_valid)
      inflight_next = inflight - IW'(1);
  end

  valid_delay_line #(.DEPTH(LATENCY)) u_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (issue),
    .dout    (dl_out)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= NO_KEY;
      kcnt        <= 2'd0;
      dcnt        <= 2'd0;
      kshadow     <= '0;
      dshadow     <= '0;
      key         <= '0;
      ciphertext  <= '0;
      settle_cnt  <= '0;
      inflight    <= '0;
      key_pending <= 1'b0;
      pt_valid    <= 1'b0;
      busy        <= 1'b0;
      key_ok      <= 1'b0;
    end else begin
      pt_valid <= dl_out;
      inflight <= inflight_next;
      busy     <= (inflight_next != '0);

      if (state == RUN && in_valid && in_is_key && !in_ready)
        key_pending <= 1'b1;
      else if (key_fire || inflight == '0)
        key_pending <= 1'b0;

      if (key_fire) begin
        kcnt    <= kcnt + 2'd1;
        kshadow <= {kshadow[SH-WORD_W-1:0], in_data};
        if (kcnt == LAST_BEAT)
          key <= {kshadow, in_data};
      end

      if (data_fire) begin
        dcnt    <= dcnt + 2'd1;
        dshadow <= {dshadow[SH-WORD_W-1:0], in_data};
        if (dcnt == LAST_BEAT)
          ciphertext <= {dshadow, in_data};
      end

      unique case (state)
        NO_KEY, RUN: begin
          if (key_fire && kcnt == LAST_BEAT) begin
            state      <= SETTLE;
            settle_cnt <= SW'(KEY_LAT);
            key_ok     <= 1'b0;
          end
        end
        SETTLE: begin
          if (settle_cnt != '0)
            settle_cnt <= settle_cnt - SW'(1);
          if (settle_cnt <= SW'(1)) begin
            state  <= RUN;
            key_ok <= 1'b1;
          end
        end
        default: state <= NO_KEY;
      endcase
    end
  end
endmodule
